btn_conditioner: RTL

Debounces and classifies the raw stopwatch push-button and sits directly upstream of the stopwatch's `start` input, on the same 1 kHz clock. It synchronizes the asynchronous button, filters contact bounce, and emits single-cycle pulses. A short press gives `short_pulse`, which drives start/stop. A long press gives `long_pulse`, which drives a clear. Both outputs are registered, so the downstream edge detector sees clean, glitch-free pulses.

---
 rtl/btn_conditioner.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/btn_conditioner.sv
// btn_conditioner
// Synchronizes, debounces and classifies the raw stopwatch push-button.
// A short press yields a one-cycle short_pulse (start/stop); a long press
// yields a one-cycle long_pulse (clear). All outputs are registered.
//
// Optional feature macro: BTN_LONG_PRESS_EN
//   defined   : long-press classification; short_pulse issued on release.
//   undefined : no long-press logic; long_pulse tied low and short_pulse
//               fires on press, together with the rise of level.

module btn_conditioner #(
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic level,
    output logic short_pulse,
    output logic long_pulse
);

    // A debounce length of 1 would give a zero-width counter, so keep one bit.
    localparam int DB_W = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_MS - 1);

    // Parameter sanity checks at elaboration time.
    if (DEBOUNCE_MS < 1) begin : g_bad_debounce
        $error("btn_conditioner: DEBOUNCE_MS must be at least 1");
    end
    if (LONG_MS < 2) begin : g_bad_long
        $error("btn_conditioner: LONG_MS must be at least 2");
    end

`ifdef BTN_LONG_PRESS_EN
    localparam int HOLD_W = $clog2(LONG_MS);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_MS - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        HELD,
        LONG_HELD,
        RELEASE_DB
    } state_t;

    logic [HOLD_W-1:0] hold_cnt;
    logic              was_long;
`else
    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        HELD,
        RELEASE_DB
    } state_t;
`endif

    state_t          state;
    logic [DB_W-1:0] db_cnt;
    logic [1:0]      sync_q;
    logic            btn_s;

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn_in};
        end
    end

    assign btn_s = sync_q[1];

    // Debounce / classification FSM with registered level and pulse outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            db_cnt      <= '0;
            level       <= 1'b0;
            short_pulse <= 1'b0;
            long_pulse  <= 1'b0;
`ifdef BTN_LONG_PRESS_EN
            hold_cnt    <= '0;
            was_long    <= 1'b0;
`endif
        end else begin
            short_pulse <= 1'b0;
            long_pulse  <= 1'b0;
            case (state)
                IDLE: begin
                    if (btn_s) begin
                        state  <= PRESS_DB;
                        db_cnt <= '0;
                    end
                end

                PRESS_DB: begin
                    if (!btn_s) begin
                        state <= IDLE;
                    end else if (db_cnt == DB_LAST) begin
                        state <= HELD;
                        level <= 1'b1;
`ifdef BTN_LONG_PRESS_EN
                        hold_cnt <= '0;
                        was_long <= 1'b0;
`else
                        short_pulse <= 1'b1;
`endif
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end

                HELD: begin
                    if (!btn_s) begin
                        // Release wins over long classification; hold_cnt freezes.
                        state  <= RELEASE_DB;
                        db_cnt <= '0;
                    end
`ifdef BTN_LONG_PRESS_EN
                    else if (hold_cnt == HOLD_LAST) begin
                        state      <= LONG_HELD;
                        long_pulse <= 1'b1;
                        was_long   <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
`endif
                end

`ifdef BTN_LONG_PRESS_EN
                LONG_HELD: begin
                    if (!btn_s) begin
                        state  <= RELEASE_DB;
                        db_cnt <= '0;
                    end
                end
`endif

                RELEASE_DB: begin
                    if (btn_s) begin
`ifdef BTN_LONG_PRESS_EN
                        if (was_long) begin
                            state <= LONG_HELD;
                        end else begin
                            // The cycle that ends a dropout already sees the
                            // button high, so it counts as held time.
                            state <= HELD;
                            if (hold_cnt != HOLD_LAST) begin
                                hold_cnt <= hold_cnt + 1'b1;
                            end
                        end
`else
                        state <= HELD;
`endif
                    end else if (db_cnt == DB_LAST) begin
                        state <= IDLE;
                        level <= 1'b0;
`ifdef BTN_LONG_PRESS_EN
                        if (!was_long) begin
                            short_pulse <= 1'b1;
                        end
`endif
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
